hilo_ctrl: RTL and testbench
============================

// Module: hilo_ctrl
// PURPOSE
//   Consumer side of the EX-stage ALU multiply/divide results. Owns the HI/LO
//   architectural registers and sequences multi-cycle DIV/DIVU by counting the
//   divider's latency, stalling the pipeline, and capturing quotient/remainder.
//   Also serves MTHI/MTLO writes and MFHI/MFLO reads, and cancels divides on flush.
// PARAMETERS
//   DIV_CYCLES  32  cycles from divide issue until ALU Result1/Result2 are valid (>=2)
// PORTS
//   clk       in   1   clock, all state on rising edge
//   rst       in   1   asynchronous, active-high reset
//   flush     in   1   synchronous pipeline flush; kills current EX op
//   op_valid  in   1   EX-stage instruction valid
//   op        in   3   0 NONE,1 MULT/MULTU,2 DIV/DIVU,3 MTHI,4 MTLO,5 MFHI,6 MFLO, 7 NONE
//   src       in   32  rs value for MTHI/MTLO
//   alu_lo    in   32  ALU Result1 (product low / quotient)
//   alu_hi    in   32  ALU Result2 (product high / remainder)
//   stall     out  1   hold IF/ID/EX; EX operands must stay stable while high
//   busy      out  1   divide in progress (state DIV_WAIT)
//   div_kill  out 1   one-cycle pulse: divide aborted by flush
//   rdata     out  32  MFHI -> hi, MFLO -> lo, otherwise 0 (combinational)
//   hi        out  32  HI register
//   lo        out  32  LO register
// BEHAVIOUR
//   - Reset (async): hi=lo=0, state IDLE, cnt=0; stall=busy=div_kill=0, rdata=0.
//   - States: IDLE, DIV_WAIT. cnt is 6-bit down counter (width covers DIV_CYCLES).
//   - IDLE, op_valid, op=MULT, !flush: hi<=alu_hi, lo<=alu_lo at edge; no stall.
//   - IDLE, op_valid, op=MTHI/MTLO, !flush: hi (resp. lo) <= src at edge.
//   - IDLE, op_valid, op=DIV, !flush: stall=1 this cycle; next state DIV_WAIT,
//     cnt<=DIV_CYCLES-1.
//   - DIV_WAIT, cnt!=0: stall=1, cnt<=cnt-1.
//   - DIV_WAIT, cnt==0: stall=0, hi<=alu_hi, lo<=alu_lo, next IDLE.
//     Net: stall high exactly DIV_CYCLES consecutive cycles; capture on edge
//     ending cycle DIV_CYCLES (issue cycle = cycle 0). EX advances that edge.
//   - stall = (IDLE & op_valid & op==DIV | DIV_WAIT & cnt!=0) & !flush.
//   - flush in DIV_WAIT: next IDLE, cnt<=0, no HI/LO write, stall=0,
//     div_kill=1 that cycle. flush in IDLE: no write of any kind, no DIV start.
//   - Op inputs other than the held DIV are ignored in DIV_WAIT.
//   - rdata reads registered hi/lo; a write in cycle N is visible from cycle N+1
//     (pipeline guarantees MF* follows its producer by >=1 cycle).
//   - MFHI/MFLO and NONE never modify state; op_valid=0 is NONE.
//   - rst asserted mid-divide: immediate return to reset values, no capture.
// TESTING
//   1 Reset mid-divide: DIV issued, rst=1 at cycle 5 -> stall=busy=0, hi=lo=0 at once.
//   2 MULT, alu_hi=FFFFFFFF alu_lo=FFFFFFFE -> next cycle hi/lo hold them; MFHI rdata=FFFFFFFF.
//   3 DIV, DIV_CYCLES=32, alu_lo=2 alu_hi=1 -> stall high cycles 0..31, low cycle 32,
//     lo=2 hi=1 from cycle 33; busy high cycles 1..32.
//   4 DIV then flush at cycle 10 -> stall=0 and div_kill=1 cycle 10; hi/lo unchanged;
//     new DIV at cycle 11 stalls full 32 cycles.
//   5 MTHI 12345678 then MFHI -> rdata=12345678; MTLO 0000ABCD with flush=1 -> lo unchanged.
//   6 DIV immediately followed by MULT -> MULT result captured one cycle after DIV capture.

Source files
------------

// File: rtl/hilo_ctrl.sv
// HI/LO register owner for the EX stage: captures MULT results, sequences
// multi-cycle DIV/DIVU with a pipeline stall, and serves MTHI/MTLO/MFHI/MFLO.
//
//   state      | meaning
//   S_IDLE     | no divide pending; MULT/MT*/DIV accepted from EX
//   S_DIV_WAIT | divide in flight; r_cnt counts down to result-valid cycle
module hilo_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_src,
  input  logic [31:0] i_alu_lo,
  input  logic [31:0] i_alu_hi,
  output logic        o_stall,
  output logic        o_busy,
  output logic        o_div_kill,
  output logic [31:0] o_rdata,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_DIV_WAIT = 1'b1;

  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;

  localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

  logic [0:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [0:0]  w_state_nxt;
  logic [5:0]  w_cnt_nxt;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic        w_idle;
  logic        w_wait;
  logic        w_div_issue;

  assign w_idle      = (r_state == S_IDLE);
  assign w_wait      = (r_state == S_DIV_WAIT);
  assign w_div_issue = w_idle & i_op_valid & (i_op == OP_DIV);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    if (w_idle) begin
      if (i_op_valid && !i_flush) begin
        case (i_op)
          OP_MULT: begin
            w_hi_nxt = i_alu_hi;
            w_lo_nxt = i_alu_lo;
          end
          OP_DIV: begin
            w_state_nxt = S_DIV_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
          OP_MTHI: w_hi_nxt = i_src;
          OP_MTLO: w_lo_nxt = i_src;
          default: ;
        endcase
      end
    end else begin
      // Flush wins over a same-cycle result capture: the divide is discarded.
      if (i_flush) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - 6'd1;
      end else begin
        w_hi_nxt    = i_alu_hi;
        w_lo_nxt    = i_alu_lo;
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  // Gated by reset so a DIV still presented on the EX inputs cannot stall during reset.
  assign o_stall    = ~i_rst & ~i_flush & (w_div_issue | (w_wait & (r_cnt != '0)));
  assign o_busy     = w_wait;
  assign o_div_kill = ~i_rst & w_wait & i_flush;

  always_comb begin
    o_rdata = '0;
    if (i_op_valid && i_op == OP_MFHI) o_rdata = r_hi;
    else if (i_op_valid && i_op == OP_MFLO) o_rdata = r_lo;
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: the driver pushes the hand-derived expected
// outputs for each cycle; a negedge monitor pops and compares them.
module tb_hilo_ctrl;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = OP_NONE;
  logic [31:0] src = '0;
  logic [31:0] alu_lo = '0;
  logic [31:0] alu_hi = '0;
  logic        stall, busy, div_kill;
  logic [31:0] rdata, hi, lo;

  hilo_ctrl #(.DIV_CYCLES(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_flush    (flush),
    .i_op_valid (op_valid),
    .i_op       (op),
    .i_src      (src),
    .i_alu_lo   (alu_lo),
    .i_alu_hi   (alu_hi),
    .o_stall    (stall),
    .o_busy     (busy),
    .o_div_kill (div_kill),
    .o_rdata    (rdata),
    .o_hi       (hi),
    .o_lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic        busy;
    logic        kill;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] eh = '0;
  logic [31:0] el = '0;

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if (stall !== e.stall) begin
        n_err++; $display("FAIL %s stall: got %0b want %0b", e.name, stall, e.stall);
      end
      if (busy !== e.busy) begin
        n_err++; $display("FAIL %s busy: got %0b want %0b", e.name, busy, e.busy);
      end
      if (div_kill !== e.kill) begin
        n_err++; $display("FAIL %s div_kill: got %0b want %0b", e.name, div_kill, e.kill);
      end
      if (rdata !== e.rdata) begin
        n_err++; $display("FAIL %s rdata: got %h want %h", e.name, rdata, e.rdata);
      end
      if (hi !== e.hi) begin
        n_err++; $display("FAIL %s hi: got %h want %h", e.name, hi, e.hi);
      end
      if (lo !== e.lo) begin
        n_err++; $display("FAIL %s lo: got %h want %h", e.name, lo, e.lo);
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] o, input logic f,
                       input logic [31:0] s, input logic [31:0] ah, input logic [31:0] al);
    op_valid = v; op = o; flush = f; src = s; alu_hi = ah; alu_lo = al;
  endtask

  // Expectation for the current cycle, then advance to just after the next edge.
  task automatic cyc(input string nm, input logic s, input logic b, input logic k,
                     input logic [31:0] rd);
    exp_t e;
    e.name = nm; e.stall = s; e.busy = b; e.kill = k; e.rdata = rd; e.hi = eh; e.lo = el;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // Reset asserted in the middle of a divide
    drive(1, OP_DIV, 0, 0, 32'h1, 32'h2);
    cyc("t1_issue", 1, 0, 0, 0);
    for (int i = 1; i < 5; i++) cyc("t1_wait", 1, 1, 0, 0);
    rst = 1'b1;
    cyc("t1_rst", 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, OP_NONE, 0, 0, 32'h1, 32'h2);
    cyc("t1_after", 0, 0, 0, 0);

    // MULT capture, then reads
    drive(1, OP_MULT, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    cyc("t2_mult", 0, 0, 0, 0);
    eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFE;
    drive(1, OP_MFHI, 0, 0, 32'h0, 32'h0);
    cyc("t2_mfhi", 0, 0, 0, 32'hFFFF_FFFF);
    drive(1, OP_MFLO, 0, 0, 32'h0, 32'h0);
    cyc("t2_mflo", 0, 0, 0, 32'hFFFF_FFFE);

    // Full-length divide
    drive(1, OP_DIV, 0, 0, 32'h1, 32'h2);
    cyc("t3_issue", 1, 0, 0, 0);
    for (int i = 1; i < 32; i++) cyc("t3_wait", 1, 1, 0, 0);
    cyc("t3_last", 0, 1, 0, 0);
    eh = 32'h1; el = 32'h2;
    drive(0, OP_NONE, 0, 0, 32'h0, 32'h0);
    cyc("t3_done", 0, 0, 0, 0);

    // Divide killed by flush, then a fresh divide
    drive(1, OP_DIV, 0, 0, 32'h6, 32'h5);
    cyc("t4_issue", 1, 0, 0, 0);
    for (int i = 1; i < 10; i++) cyc("t4_wait", 1, 1, 0, 0);
    flush = 1'b1;
    cyc("t4_flush", 0, 1, 1, 0);
    drive(1, OP_DIV, 0, 0, 32'hB, 32'hA);
    cyc("t4_reissue", 1, 0, 0, 0);
    for (int i = 12; i < 43; i++) cyc("t4_wait2", 1, 1, 0, 0);
    cyc("t4_last", 0, 1, 0, 0);
    eh = 32'hB; el = 32'hA;
    drive(0, OP_NONE, 0, 0, 32'h0, 32'h0);
    cyc("t4_done", 0, 0, 0, 0);

    // MTHI/MTLO, flushed MTLO and flushed DIV in IDLE
    drive(1, OP_MTHI, 0, 32'h1234_5678, 32'h0, 32'h0);
    cyc("t5_mthi", 0, 0, 0, 0);
    eh = 32'h1234_5678;
    drive(1, OP_MFHI, 0, 0, 32'h0, 32'h0);
    cyc("t5_mfhi", 0, 0, 0, 32'h1234_5678);
    drive(1, OP_MTLO, 1, 32'h0000_ABCD, 32'h0, 32'h0);
    cyc("t5_mtlo_fl", 0, 0, 0, 0);
    drive(1, OP_MFLO, 0, 0, 32'h0, 32'h0);
    cyc("t5_mflo", 0, 0, 0, 32'hA);
    drive(1, OP_DIV, 1, 0, 32'h7, 32'h7);
    cyc("t5_div_fl", 0, 0, 0, 0);
    drive(1, OP_MULT, 1, 0, 32'h7, 32'h7);
    cyc("t5_mult_fl", 0, 0, 0, 0);

    // Divide followed directly by MULT
    drive(1, OP_DIV, 0, 0, 32'h22, 32'h11);
    cyc("t6_issue", 1, 0, 0, 0);
    for (int i = 1; i < 32; i++) cyc("t6_wait", 1, 1, 0, 0);
    cyc("t6_last", 0, 1, 0, 0);
    eh = 32'h22; el = 32'h11;
    drive(1, OP_MULT, 0, 0, 32'h33, 32'h44);
    cyc("t6_mult", 0, 0, 0, 0);
    eh = 32'h33; el = 32'h44;
    drive(0, OP_NONE, 0, 0, 32'h0, 32'h0);
    cyc("t6_done", 0, 0, 0, 0);

    @(posedge clk); #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
